// File: rtl/seq_det_ctrl.sv
// Programmable nibble-sequence detector: config-port pattern/length, valid/ready
// stream input, non-overlapping match pulses, saturating match count, partial-match timeout.
module seq_det_ctrl #(
    parameter int DW      = 4,
    parameter int MAX_LEN = 6,
    parameter int TO_CYC  = 16,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [2:0]       cfg_idx,
    input  logic [DW-1:0]    cfg_data,
    input  logic             cfg_len_we,
    input  logic [2:0]       cfg_len,
    input  logic             start,
    input  logic             stop,
    input  logic [DW-1:0]    din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             match,
    output logic             timeout,
    output logic             cfg_err,
    output logic             busy,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int         TW      = $clog2(TO_CYC + 1);
    localparam logic [2:0] MAX_IDX = 3'(MAX_LEN);
    localparam logic [TW-1:0] TO_LAST = TW'(TO_CYC - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    state_e           state_q;
    logic [DW-1:0]    pat_q [MAX_LEN];
    logic [2:0]       len_q;
    logic [2:0]       idx_q;
    logic [TW-1:0]    timer_q;
    logic [CNT_W-1:0] cnt_q;
    logic             match_q;
    logic             timeout_q;
    logic             cfg_err_q;
    logic             busy_q;

    logic accept;
    logic hit;
    logic last;
    logic first_hit;

    always_comb begin
        din_ready = (state_q == SCAN) & ~stop;
        accept    = din_valid & din_ready;
        hit       = (din == pat_q[idx_q]);
        first_hit = (din == pat_q[0]);
        last      = (idx_q == (len_q - 3'd1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pat_q     <= '{default: '0};
            len_q     <= '0;
            idx_q     <= '0;
            timer_q   <= '0;
            cnt_q     <= '0;
            match_q   <= 1'b0;
            timeout_q <= 1'b0;
            cfg_err_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            match_q   <= 1'b0;
            timeout_q <= 1'b0;
            cfg_err_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (cfg_we) begin
                        if (cfg_idx < MAX_IDX) pat_q[cfg_idx] <= cfg_data;
                        else                   cfg_err_q <= 1'b1;
                    end
                    if (cfg_len_we) begin
                        if ((cfg_len != 3'd0) && (cfg_len <= MAX_IDX)) len_q <= cfg_len;
                        else                                           cfg_err_q <= 1'b1;
                    end
                    // start is qualified by the length held before this edge
                    if (start) begin
                        if (len_q == 3'd0) begin
                            cfg_err_q <= 1'b1;
                        end else begin
                            state_q <= SCAN;
                            busy_q  <= 1'b1;
                            idx_q   <= '0;
                            timer_q <= '0;
                            cnt_q   <= '0;
                        end
                    end
                end
                SCAN: begin
                    if (cfg_we || cfg_len_we) cfg_err_q <= 1'b1;
                    if (stop) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        idx_q   <= '0;
                        timer_q <= '0;
                    end else if (accept) begin
                        timer_q <= '0;
                        if (hit && last) begin
                            match_q <= 1'b1;
                            idx_q   <= '0;
                            if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
                        end else if (hit) begin
                            idx_q <= idx_q + 3'd1;
                        end else if (first_hit && (len_q == 3'd1)) begin
                            match_q <= 1'b1;
                            idx_q   <= '0;
                            if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
                        end else if (first_hit) begin
                            idx_q <= 3'd1;
                        end else begin
                            idx_q <= '0;
                        end
                    end else if (idx_q != 3'd0) begin
                        if (timer_q == TO_LAST) begin
                            timeout_q <= 1'b1;
                            idx_q     <= '0;
                            timer_q   <= '0;
                        end else begin
                            timer_q <= timer_q + TW'(1);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign match     = match_q;
    assign timeout   = timeout_q;
    assign cfg_err   = cfg_err_q;
    assign busy      = busy_q;
    assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed bench for seq_det_ctrl: default instance plus a CNT_W=2 instance on shared inputs.
module tb_seq_det_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_we;
    logic [2:0] cfg_idx;
    logic [3:0] cfg_data;
    logic       cfg_len_we;
    logic [2:0] cfg_len;
    logic       start;
    logic       stop;
    logic [3:0] din;
    logic       din_valid;

    logic       din_ready, match, timeout, cfg_err, busy;
    logic [7:0] match_cnt;
    logic       s_ready, s_match, s_timeout, s_err, s_busy;
    logic [1:0] s_cnt;

    int total = 0;
    int bad   = 0;
    int mcnt, scnt, tcnt;

    always #5 clk = ~clk;

    seq_det_ctrl u_dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
        .cfg_len_we(cfg_len_we), .cfg_len(cfg_len), .start(start), .stop(stop),
        .din(din), .din_valid(din_valid), .din_ready(din_ready), .match(match),
        .timeout(timeout), .cfg_err(cfg_err), .busy(busy), .match_cnt(match_cnt)
    );

    seq_det_ctrl #(.CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
        .cfg_len_we(cfg_len_we), .cfg_len(cfg_len), .start(start), .stop(stop),
        .din(din), .din_valid(din_valid), .din_ready(s_ready), .match(s_match),
        .timeout(s_timeout), .cfg_err(s_err), .busy(s_busy), .match_cnt(s_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (match)   mcnt++;
        if (s_match) scnt++;
        if (timeout) tcnt++;
    endtask

    task automatic clr();
        mcnt = 0;
        scnt = 0;
        tcnt = 0;
    endtask

    task automatic cfg_wr(input logic [2:0] idx, input logic [3:0] data);
        cfg_we = 1'b1; cfg_idx = idx; cfg_data = data;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic set_len(input logic [2:0] len);
        cfg_len_we = 1'b1; cfg_len = len;
        tick();
        cfg_len_we = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    // nibbles are sent most-significant first
    task automatic stream(input logic [63:0] nib, input int n);
        for (int i = 0; i < n; i++) begin
            din       = nib[4*(n-1-i) +: 4];
            din_valid = 1'b1;
            tick();
        end
        din_valid = 1'b0;
    endtask

    task automatic program_main();
        cfg_wr(3'd0, 4'h1); cfg_wr(3'd1, 4'h3); cfg_wr(3'd2, 4'h4);
        cfg_wr(3'd3, 4'h8); cfg_wr(3'd4, 4'hD); cfg_wr(3'd5, 4'h9);
        set_len(3'd6);
    endtask

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_data = '0; cfg_len_we = 1'b0;
        cfg_len = '0; start = 1'b0; stop = 1'b0; din = '0; din_valid = 1'b0;
        clr();
        tick(); tick();
        rst = 1'b0;

        chk("rst_match", {31'd0, match}, 32'd0);
        chk("rst_timeout", {31'd0, timeout}, 32'd0);
        chk("rst_cfg_err", {31'd0, cfg_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_cnt", {24'd0, match_cnt}, 32'd0);
        chk("rst_ready", {31'd0, din_ready}, 32'd0);
        chk("rst_sat_flags", {27'd0, s_ready, s_match, s_timeout, s_err, s_busy}, 32'd0);

        // illegal lengths and start with no length programmed
        set_len(3'd0);
        chk("len0_err", {31'd0, cfg_err}, 32'd1);
        tick();
        chk("err_pulse_1cyc", {31'd0, cfg_err}, 32'd0);
        pulse_start();
        chk("start_len0_err", {31'd0, cfg_err}, 32'd1);
        chk("start_len0_busy", {31'd0, busy}, 32'd0);
        set_len(3'd7);
        chk("len7_err", {31'd0, cfg_err}, 32'd1);
        pulse_start();
        chk("start_len7_err", {31'd0, cfg_err}, 32'd1);
        chk("start_len7_busy", {31'd0, busy}, 32'd0);
        cfg_wr(3'd6, 4'hA);
        chk("idx6_err", {31'd0, cfg_err}, 32'd1);

        // basic match; config writes in SCAN must be rejected
        program_main();
        chk("len6_ok", {31'd0, cfg_err}, 32'd0);
        pulse_start();
        chk("start_busy", {31'd0, busy}, 32'd1);
        chk("start_cnt0", {24'd0, match_cnt}, 32'd0);
        cfg_wr(3'd0, 4'hF);
        chk("scan_cfgwe_err", {31'd0, cfg_err}, 32'd1);
        set_len(3'd2);
        chk("scan_lenwe_err", {31'd0, cfg_err}, 32'd1);
        chk("scan_ready", {31'd0, din_ready}, 32'd1);
        clr();
        stream(64'h1348D9, 6);
        chk("t1_match_pulse", {31'd0, match}, 32'd1);
        chk("t1_matches", mcnt, 32'd1);
        chk("t1_cnt", {24'd0, match_cnt}, 32'd1);
        tick();
        chk("t1_match_1cyc", {31'd0, match}, 32'd0);

        // mismatch on the repeated 1 restarts at index 1
        pulse_stop(); pulse_start(); clr();
        stream(64'h131348D9, 8);
        chk("t2_matches", mcnt, 32'd1);
        chk("t2_cnt", {24'd0, match_cnt}, 32'd1);

        // non-overlapping len=2 pattern 5,5
        pulse_stop();
        cfg_wr(3'd0, 4'h5); cfg_wr(3'd1, 4'h5); set_len(3'd2);
        pulse_start(); clr();
        stream(64'h5555, 4);
        chk("t3_matches", mcnt, 32'd2);
        chk("t3_cnt", {24'd0, match_cnt}, 32'd2);
        chk("t3_sat_cnt", {30'd0, s_cnt}, 32'd2);

        // len=1: every nibble equal to pat[0] matches
        pulse_stop();
        cfg_wr(3'd0, 4'h7); set_len(3'd1);
        pulse_start(); clr();
        stream(64'h727, 3);
        chk("len1_matches", mcnt, 32'd2);
        chk("len1_cnt", {24'd0, match_cnt}, 32'd2);

        // inter-nibble timeout after a partial match
        pulse_stop();
        cfg_wr(3'd0, 4'h1); cfg_wr(3'd1, 4'h3); set_len(3'd6);
        pulse_start(); clr();
        stream(64'h13, 2);
        repeat (15) tick();
        chk("t4_no_early_to", tcnt, 32'd0);
        tick();
        chk("t4_timeout", {31'd0, timeout}, 32'd1);
        tick();
        chk("t4_timeout_1cyc", {31'd0, timeout}, 32'd0);
        chk("t4_timeouts", tcnt, 32'd1);
        clr();
        stream(64'h348D9, 5);
        chk("t4_no_match", mcnt, 32'd0);
        repeat (20) tick();
        chk("t4_no_to_idle", tcnt, 32'd0);
        chk("t4_cnt", {24'd0, match_cnt}, 32'd0);

        // saturation, start ignored in SCAN, stop with valid mid-pattern
        pulse_stop(); pulse_start(); clr();
        repeat (5) stream(64'h1348D9, 6);
        chk("t6_matches", mcnt, 32'd5);
        chk("t6_cnt", {24'd0, match_cnt}, 32'd5);
        chk("t6_sat_matches", scnt, 32'd5);
        chk("t6_sat_cnt", {30'd0, s_cnt}, 32'd3);
        pulse_start();
        chk("t6_start_ign_cnt", {24'd0, match_cnt}, 32'd5);
        chk("t6_start_ign_busy", {31'd0, busy}, 32'd1);
        stream(64'h13, 2);
        din = 4'h4; din_valid = 1'b1; stop = 1'b1;
        #1;
        chk("t6_stop_ready", {31'd0, din_ready}, 32'd0);
        tick();
        stop = 1'b0; din_valid = 1'b0;
        chk("t6_stop_busy", {31'd0, busy}, 32'd0);
        chk("t6_stop_cnt", {24'd0, match_cnt}, 32'd5);
        chk("t6_stop_sat_cnt", {30'd0, s_cnt}, 32'd3);
        pulse_start(); clr();
        stream(64'h48D9, 4);
        chk("t6_idx_cleared", mcnt, 32'd0);

        // reset mid-SCAN loses pattern and length
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_scan_busy", {31'd0, busy}, 32'd0);
        chk("rst_scan_cnt", {24'd0, match_cnt}, 32'd0);
        pulse_start();
        chk("rst_scan_start_err", {31'd0, cfg_err}, 32'd1);
        chk("rst_scan_start_busy", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
